// File: rtl/amount_entry_ctrl.sv
// amount_entry_ctrl
//   Turns the keypad scanner's debounced key stream into the amount-entry
//   dialogue. It detects single key events from the press level and builds
//   a decimal amount from digit keys. It validates the amount when CONFIRM
//   is pressed, then holds the confirmed amount for the charge controller
//   until that controller acknowledges it.
//
// Ports
//   clk           1 kHz system clock (same divided clock as the scanner)
//   rst_n         asynchronous reset, active-HIGH (legacy naming)
//   press         scanner "key held & stable" level
//   key_value     key code: 0-9 digit, A start, B clear, C confirm, D-F unused
//   ack           charge controller has taken the amount (level or pulse)
//   amount        current entered / confirmed amount, binary
//   digit_cnt     digits entered so far
//   entry_active  high while an entry is in progress
//   amount_valid  high while a confirmed amount is being held
//   start_pulse   1-cycle: entry started
//   clear_pulse   1-cycle: entry cleared by CLEAR
//   err_pulse     1-cycle: CONFIRM rejected
//   timeout_pulse 1-cycle: entry aborted by inactivity
module amount_entry_ctrl #(
    parameter int MAX_DIGITS = 2,
    parameter int MAX_AMOUNT = 20,
    parameter int TIMEOUT    = 10000,
    parameter int AW         = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          press,
    input  logic [3:0]    key_value,
    input  logic          ack,
    output logic [AW-1:0] amount,
    output logic [1:0]    digit_cnt,
    output logic          entry_active,
    output logic          amount_valid,
    output logic          start_pulse,
    output logic          clear_pulse,
    output logic          err_pulse,
    output logic          timeout_pulse
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] KEY_START   = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    localparam logic [3:0] KEY_CONFIRM = 4'hC;

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    state_t          state, state_nxt;
    logic            press_d;
    logic [TW-1:0]   timer, timer_nxt;
    logic [AW-1:0]   amount_nxt;
    logic [1:0]      cnt_nxt;
    logic            sp_nxt, cp_nxt, ep_nxt, tp_nxt;
    logic            key_evt;
    logic            accepted;
    logic [AW+3:0]   mac;

    // Rising edge of the press level: one event per key press, no repeats.
    assign key_evt = press & ~press_d;

    // Decimal shift-in with headroom; MAX_DIGITS bounds the result to AW bits.
    assign mac = (AW+4)'(amount) * (AW+4)'(10) + (AW+4)'(key_value);

    assign entry_active = (state == ENTRY);
    assign amount_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            press_d       <= 1'b0;
            timer         <= '0;
            amount        <= '0;
            digit_cnt     <= '0;
            start_pulse   <= 1'b0;
            clear_pulse   <= 1'b0;
            err_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            press_d       <= press;
            timer         <= timer_nxt;
            amount        <= amount_nxt;
            digit_cnt     <= cnt_nxt;
            start_pulse   <= sp_nxt;
            clear_pulse   <= cp_nxt;
            err_pulse     <= ep_nxt;
            timeout_pulse <= tp_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        amount_nxt = amount;
        cnt_nxt    = digit_cnt;
        sp_nxt     = 1'b0;
        cp_nxt     = 1'b0;
        ep_nxt     = 1'b0;
        tp_nxt     = 1'b0;
        accepted   = 1'b0;

        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (key_evt && key_value == KEY_START) begin
                    state_nxt  = ENTRY;
                    amount_nxt = '0;
                    cnt_nxt    = '0;
                    sp_nxt     = 1'b1;
                end
            end

            ENTRY: begin
                // START, D-F and digits beyond the limit are not accepted
                // and therefore do not restart the inactivity timer.
                if (key_evt) begin
                    if (key_value <= 4'd9) begin
                        if (digit_cnt < 2'(MAX_DIGITS)) begin
                            amount_nxt = mac[AW-1:0];
                            cnt_nxt    = digit_cnt + 2'd1;
                            accepted   = 1'b1;
                        end
                    end else if (key_value == KEY_CLEAR) begin
                        amount_nxt = '0;
                        cnt_nxt    = '0;
                        cp_nxt     = 1'b1;
                        accepted   = 1'b1;
                    end else if (key_value == KEY_CONFIRM) begin
                        accepted = 1'b1;
                        if (digit_cnt == 2'd0 || amount == '0) begin
                            ep_nxt = 1'b1;
                        end else if (amount > AW'(MAX_AMOUNT)) begin
                            ep_nxt     = 1'b1;
                            amount_nxt = '0;
                            cnt_nxt    = '0;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end

                // An accepted key in the expiry cycle wins over the abort.
                if (accepted) begin
                    timer_nxt = '0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt  = IDLE;
                    amount_nxt = '0;
                    cnt_nxt    = '0;
                    tp_nxt     = 1'b1;
                    timer_nxt  = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            DONE: begin
                timer_nxt = '0;
                if (ack) begin
                    state_nxt  = IDLE;
                    amount_nxt = '0;
                    cnt_nxt    = '0;
                end
            end

            default: begin
                state_nxt  = IDLE;
                amount_nxt = '0;
                cnt_nxt    = '0;
                timer_nxt  = '0;
            end
        endcase
    end

endmodule
